// File: rtl/moore_stream_if.sv
// Producer-side handshake bundle for moore_stream_ctrl.
//   start        producer -> ctrl  request, accepted only while the controller is idle
//   data_in      producer -> ctrl  parallel word captured on the accepted start cycle
//   busy         ctrl -> producer  high from the cycle after accept until DONE exits
//   done         ctrl -> producer  one-cycle pulse, match_count valid
//   match_count  ctrl -> producer  number of post-bit detector samples with det_y=1
// Modports: master = producer, slave = controller.
interface moore_stream_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    match_count;

  modport master (
    output start, data_in,
    input  busy, done, match_count
  );

  modport slave (
    input  start, data_in,
    output busy, done, match_count
  );
endinterface

// File: rtl/moore_stream_ctrl.sv
// moore_stream_ctrl: sequencer for a single-bit Moore sequence detector.
// Captures a parallel word on start, pulses a detector clear, shifts the word
// into the detector one bit per clock, counts how many bit-steps left the
// detector output high, then pulses done.
//
// Ports:
//   clock    in   single clock, all state updates on posedge
//   reset    in   synchronous active-high reset
//   bus      slave modport of moore_stream_if (start, data_in, busy, done, match_count)
//   det_y    in   Moore output of the controlled detector
//   det_in   out  serial bit to the detector input (0 outside SHIFT)
//   det_clr  out  one-cycle synchronous clear to the detector (CLEAR only)
//
// Build option: define STREAM_CTRL_LSB_FIRST_EN to send bit 0 first; the
// default build sends the MSB first. Timing and counts are identical.
//
// Timing (start accepted in cycle T): CLEAR at T+1, SHIFT T+2..T+WIDTH+1,
// DRAIN T+WIDTH+2, DONE T+WIDTH+3, IDLE again at T+WIDTH+4.
module moore_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  moore_stream_if.slave        bus,
  input  logic                 det_y,
  output logic                 det_in,
  output logic                 det_clr
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;

  // Bit order is the only thing the build option changes.
  logic             out_bit;
  logic [WIDTH-1:0] shreg_next;

`ifdef STREAM_CTRL_LSB_FIRST_EN
  assign out_bit    = shreg[0];
  assign shreg_next = shreg >> 1;
`else
  assign out_bit    = shreg[WIDTH-1];
  assign shreg_next = shreg << 1;
`endif

  // det_in is a registered output, so each bit is loaded one cycle ahead:
  // CLEAR loads the first bit and every SHIFT cycle but the last loads the
  // next one. The detector sees the same bit per SHIFT cycle as if det_in
  // were decoded from the current shreg head.
  //
  // det_y sampling: the detector's response to the bit of SHIFT cycle k is
  // visible in SHIFT cycle k+1 (or DRAIN for the last bit), so the first
  // SHIFT cycle (bit_cnt == LAST_IDX) is skipped and DRAIN is included,
  // giving exactly WIDTH samples.

  // NOTE: every register here is assigned with <= so all updates see the
  // values from before the clock edge; a blocking = would let later lines
  // read already-updated state and break the one-cycle-ahead bit loading.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      bus.match_count <= '0;
      det_in          <= 1'b0;
      det_clr         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      // Pulse outputs default low; only the transition into CLEAR / DONE raises them.
      det_clr  <= 1'b0;
      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg           <= bus.data_in;
            bus.match_count <= '0;
            det_clr         <= 1'b1;
            bus.busy        <= 1'b1;
            state           <= CLEAR;
          end
        end

        CLEAR: begin
          bit_cnt <= LAST_IDX;
          det_in  <= out_bit;
          shreg   <= shreg_next;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt != LAST_IDX) begin
            bus.match_count <= bus.match_count + CW'(det_y);
          end
          if (bit_cnt == '0) begin
            det_in <= 1'b0;
            state  <= DRAIN;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            det_in  <= out_bit;
            shreg   <= shreg_next;
          end
        end

        DRAIN: begin
          bus.match_count <= bus.match_count + CW'(det_y);
          bus.done        <= 1'b1;
          state           <= DONE;
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          det_in   <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Directed bench for moore_stream_ctrl (WIDTH=8) with a stub detector
// (det_y <= det_in, cleared by det_clr) whose match count equals the popcount
// of the word. force_ones overrides det_y to 1 to exercise the count ceiling.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_moore_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clock = 1'b0;
  logic reset;
  logic det_y;
  logic det_in;
  logic det_clr;
  logic stub_y;
  logic force_ones;

  int n_checks = 0;
  int n_pass   = 0;

  moore_stream_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  moore_stream_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .det_y   (det_y),
    .det_in  (det_in),
    .det_clr (det_clr)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset || det_clr) stub_y <= 1'b0;
    else                  stub_y <= det_in;
  end

  assign det_y = force_ones | stub_y;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic int popcount(input logic [WIDTH-1:0] d);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(d[i]);
    return n;
  endfunction

  // Bit presented on det_in in the i-th SHIFT cycle (i = 0 first).
  function automatic logic sent_bit(input logic [WIDTH-1:0] d, input int i);
`ifdef STREAM_CTRL_LSB_FIRST_EN
    return d[i];
`else
    return d[WIDTH-1-i];
`endif
  endfunction

  // Starts at a falling edge of an IDLE cycle (cycle T) and ends at cycle T+12.
  // hold  : keep start high and scramble data_in for the whole transfer.
  // chain : raise start with next_d on the DONE cycle (must be ignored).
  task automatic transfer(input logic [WIDTH-1:0] d, input bit hold,
                          input bit chain, input logic [WIDTH-1:0] next_d);
    int exp_cnt;
    exp_cnt = force_ones ? WIDTH : popcount(d);
    bus.start   = 1'b1;
    bus.data_in = d;
    step();  // T+1: CLEAR
    bus.start   = hold;
    bus.data_in = hold ? WIDTH'($urandom) : ~d;
    check("clr_det_clr", det_clr, 1);
    check("clr_busy", bus.busy, 1);
    check("clr_det_in", det_in, 0);
    check("clr_count", bus.match_count, 0);
    for (int i = 0; i < WIDTH; i++) begin
      step();  // T+2+i: SHIFT
      if (hold) bus.data_in = WIDTH'($urandom);
      check($sformatf("shift%0d_det_in", i), det_in, sent_bit(d, i));
      check($sformatf("shift%0d_ctl", i), {bus.busy, bus.done, det_clr}, 3'b100);
    end
    step();  // T+10: DRAIN
    check("drain_ctl", {det_in, bus.busy, bus.done, det_clr}, 4'b0100);
    step();  // T+11: DONE
    if (chain) begin
      bus.start   = 1'b1;
      bus.data_in = next_d;
    end
    check("done_ctl", {det_in, bus.busy, bus.done, det_clr}, 4'b0110);
    check("done_count", bus.match_count, exp_cnt);
    step();  // T+12: IDLE
    check("idle_ctl", {det_in, bus.busy, bus.done, det_clr}, 4'b0000);
    check("idle_count", bus.match_count, exp_cnt);
    if (!hold && !chain) bus.start = 1'b0;
  endtask

  initial begin
    int  seen_done;
    reset       = 1'b1;
    force_ones  = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    step();
    step();
    check("rst_outputs", {det_in, det_clr, bus.busy, bus.done}, 4'b0000);
    check("rst_count", bus.match_count, 0);
    reset = 1'b0;
    step();

    // Word B4 (default build: 1,0,1,1,0,1,0,0), count 4, done at T+11.
    transfer(8'hB4, 1'b0, 1'b0, 8'h00);
    step();

    // 00 then FF; the start on the DONE cycle is ignored, accept the cycle after.
    transfer(8'h00, 1'b0, 1'b1, 8'hFF);
    transfer(8'hFF, 1'b0, 1'b0, 8'h00);
    step();

    // LSB-first checks land on this word in that build: only the first bit set.
    transfer(8'h01, 1'b0, 1'b0, 8'h00);
    step();

    // start held high with data_in changing every cycle.
    transfer(8'h96, 1'b1, 1'b0, 8'h00);
    transfer(8'h3A, 1'b0, 1'b0, 8'h00);
    step();

    // Reset in cycle T+5 of a transfer.
    bus.start   = 1'b1;
    bus.data_in = 8'hA5;
    step();  // T+1
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();  // T+5
    reset = 1'b1;
    step();  // T+6
    check("midrst_outputs", {det_in, det_clr, bus.busy, bus.done}, 4'b0000);
    check("midrst_count", bus.match_count, 0);
    reset     = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.busy) seen_done++;
    end
    check("midrst_quiet", seen_done, 0);
    transfer(8'h5A, 1'b0, 1'b0, 8'h00);
    step();

    // det_y stuck high: count saturates at WIDTH and holds through IDLE.
    force_ones = 1'b1;
    transfer(8'h3C, 1'b0, 1'b0, 8'h00);
    step();
    step();
    step();
    check("ones_idle_hold", bus.match_count, WIDTH);
    force_ones = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
